// File: rtl/threshold_adapt_pkg.sv
// threshold_adapt_pkg: shared FSM state and update-mode encodings for threshold_adapt_mc.
package threshold_adapt_pkg;
  typedef enum logic {INIT, RUN} state_t;
  localparam logic MODE_ADD  = 1'b0;
  localparam logic MODE_DMIN = 1'b1;
endpackage

// File: rtl/ta_clamp_calc.sv
// ta_clamp_calc: one threshold update (additive or dmin tracking) followed by the tup/tlow clamp.
module ta_clamp_calc
  import threshold_adapt_pkg::*;
#(
  parameter int W     = 16,
  parameter int SHIFT = 3
) (
  input  logic [W-1:0] i_t,
  input  logic         i_fx,
  input  logic         i_mode,
  input  logic [W-1:0] i_dmin,
  input  logic [W-1:0] i_tinc,
  input  logic [W-1:0] i_tdec,
  input  logic [W-1:0] i_tup,
  input  logic [W-1:0] i_tlow,
  output logic [W-1:0] o_n,
  output logic         o_sat
);
  logic signed [W+1:0] w_t, w_dm, w_inc, w_dec, w_up, w_lo, w_dlt, w_n, w_c;
  assign w_t   = {2'b00, i_t};
  assign w_dm  = {2'b00, i_dmin};
  assign w_inc = {2'b00, i_tinc};
  assign w_dec = {2'b00, i_tdec};
  assign w_up  = {2'b00, i_tup};
  assign w_lo  = {2'b00, i_tlow};
  // Signed shift so a dmin below t pulls the threshold down, rounding toward -inf.
  assign w_dlt = (w_dm - w_t) >>> SHIFT;
  assign w_n   = i_fx ? w_t + w_inc : (i_mode == MODE_DMIN) ? w_t + w_dlt : w_t - w_dec;
  // Lower clamp is applied last, so tlow > tup resolves to tlow.
  assign w_c   = (w_n > w_up) ? w_up : w_n;
  assign o_n   = (w_c < w_lo) ? i_tlow : w_c[W-1:0];
  assign o_sat = (w_n > w_up) || (w_c < w_lo);
endmodule

// File: rtl/threshold_adapt_mc.sv
// threshold_adapt_mc: per-channel adaptive threshold bank with init sweep and a 2-stage update pipeline.
module threshold_adapt_mc
  import threshold_adapt_pkg::*;
#(
  parameter int             W      = 16,
  parameter int             FRAC   = 8,
  parameter int             N_CH   = 8,
  parameter int             SHIFT  = 3,
  parameter logic [W-1:0]   T_INIT = 16'h0200,
  localparam int            CH_W   = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_mode,
  input  logic [W-1:0]    i_tinc,
  input  logic [W-1:0]    i_tdec,
  input  logic [W-1:0]    i_tup,
  input  logic [W-1:0]    i_tlow,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [CH_W-1:0] i_in_ch,
  input  logic            i_in_fx,
  input  logic [W-1:0]    i_in_dmin,
  output logic            o_out_valid,
  output logic [CH_W-1:0] o_out_ch,
  output logic [W-1:0]    o_out_tx,
  output logic            o_out_sat
);
  localparam logic [CH_W:0]   NCH  = (CH_W+1)'(N_CH);
  localparam logic [CH_W-1:0] LAST = CH_W'(N_CH - 1);
  if (FRAC > W) begin : g_frac_chk
    $error("FRAC must not exceed W");
  end
  state_t          r_state, w_state_nx;
  logic [CH_W-1:0] r_ptr, w_ptr_nx, w_wa;
  logic [W-1:0]    r_bank [N_CH];
  logic            w_acc, w_inr, w_hit, w_we, w_sat;
  logic [W-1:0]    w_rd, w_wd, w_n;
  logic            r1_v, r1_fx, r1_mode;
  logic [CH_W-1:0] r1_ch;
  logic [W-1:0]    r1_t, r1_dmin, r1_tinc, r1_tdec, r1_tup, r1_tlow;
  assign o_in_ready = (r_state == RUN);
  assign w_acc      = i_in_valid && o_in_ready && !i_clr;
  assign w_inr      = {1'b0, i_in_ch} < NCH;
  // Forward the result S2 is writing this edge so back-to-back updates chain.
  assign w_hit      = r1_v && (r1_ch == i_in_ch);
  assign w_rd       = w_hit ? w_n : w_inr ? r_bank[i_in_ch] : '0;
  ta_clamp_calc #(.W(W), .SHIFT(SHIFT)) u_calc (
    .i_t(r1_t), .i_fx(r1_fx), .i_mode(r1_mode), .i_dmin(r1_dmin),
    .i_tinc(r1_tinc), .i_tdec(r1_tdec), .i_tup(r1_tup), .i_tlow(r1_tlow),
    .o_n(w_n), .o_sat(w_sat)
  );
  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_we       = r1_v && !i_clr;
    w_wa       = r1_ch;
    w_wd       = w_n;
    if (i_clr) begin
      w_state_nx = INIT;
      w_ptr_nx   = '0;
    end else if (r_state == INIT) begin
      w_we       = 1'b1;
      w_wa       = r_ptr;
      w_wd       = T_INIT;
      w_ptr_nx   = r_ptr + 1'b1;
      w_state_nx = (r_ptr == LAST) ? RUN : INIT;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (w_we) r_bank[w_wa] <= w_wd;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v        <= 1'b0;
      r1_fx       <= 1'b0;
      r1_mode     <= MODE_ADD;
      r1_ch       <= '0;
      r1_t        <= '0;
      r1_dmin     <= '0;
      r1_tinc     <= '0;
      r1_tdec     <= '0;
      r1_tup      <= '0;
      r1_tlow     <= '0;
      o_out_valid <= 1'b0;
      o_out_ch    <= '0;
      o_out_tx    <= '0;
      o_out_sat   <= 1'b0;
    end else begin
      r1_v        <= w_acc && w_inr;
      o_out_valid <= r1_v && !i_clr;
      if (w_acc) begin
        r1_fx   <= i_in_fx;
        r1_mode <= i_mode;
        r1_ch   <= i_in_ch;
        r1_t    <= w_rd;
        r1_dmin <= i_in_dmin;
        r1_tinc <= i_tinc;
        r1_tdec <= i_tdec;
        r1_tup  <= i_tup;
        r1_tlow <= i_tlow;
      end
      if (r1_v) begin
        o_out_ch  <= r1_ch;
        o_out_tx  <= w_n;
        o_out_sat <= w_sat;
      end
    end
  end
endmodule
